// File: rtl/proj_fm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : proj_fm_pkg                                                      |
// | Purpose : Shared types, default geometry and base helpers for the          |
// |           fragment-memory ring projector.                                  |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial ring-buffer release                                 |
// +----------------------------------------------------------------------------+
package proj_fm_pkg;

  localparam int DEF_BUFFER_COUNT = 4;
  localparam int DEF_BUF_DEPTH    = 32;
  localparam int DEF_DATA_BITS    = 2;
  localparam int DEF_FRAG_BASES   = 8;
  localparam int DEF_FRAG_LEN     = DEF_FRAG_BASES * DEF_DATA_BITS;

  typedef logic [DEF_DATA_BITS-1:0] base_t;

  // With the 2-bit A/C/G/T encoding (00/01/10/11), the bitwise inverse of a
  // base is its Watson-Crick complement.
  function automatic base_t complement_base(input base_t b);
    return ~b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/proj_fm_frag_extract.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : proj_fm_frag_extract                                             |
// | Purpose : Combinational fragment slicer. Picks FRAG_BASES bases from one   |
// |           flattened buffer image starting at a signed index, zero-pads     |
// |           positions outside the buffer and optionally reverse-complements. |
// | Ports   : buf_img  - buffer image, base a at [a*DATA_BITS +: DATA_BITS]    |
// |           frag_idx - signed start index (two's complement)                 |
// |           rc_mode  - 1 = reverse-complement read                           |
// |           frag     - fragment, base j at [j*DATA_BITS +: DATA_BITS]        |
// | Rev     : 1.0  initial ring-buffer release                                 |
// +----------------------------------------------------------------------------+
module proj_fm_frag_extract
  import proj_fm_pkg::*;
#(
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int FRAG_BASES = DEF_FRAG_BASES,
  parameter int IDX_LEN    = $clog2(BUF_DEPTH) + 1,
  parameter int FRAG_LEN   = FRAG_BASES * DATA_BITS
) (
  input  logic [BUF_DEPTH*DATA_BITS-1:0] buf_img,
  input  logic [IDX_LEN-1:0]             frag_idx,
  input  logic                           rc_mode,
  output logic [FRAG_LEN-1:0]            frag
);

  localparam int c_AW = $clog2(BUF_DEPTH);
  localparam int c_PW = IDX_LEN + 1;

  for (genvar j = 0; j < FRAG_BASES; j++) begin : g_base
    logic [c_PW-1:0]      w_pos;
    logic                 w_in_range;
    logic [c_AW-1:0]      w_addr;
    logic [DATA_BITS-1:0] w_raw;
    logic [DATA_BITS-1:0] w_cmp;

    // Sign-extend by one bit so frag_idx + j cannot overflow.
    assign w_pos      = {frag_idx[IDX_LEN-1], frag_idx} + c_PW'(j);
    assign w_in_range = ~w_pos[c_PW-1] && (w_pos < c_PW'(BUF_DEPTH));
    // BUF_DEPTH is a power of two, so BUF_DEPTH-1-p is the bitwise inverse
    // of p within the address width.
    assign w_addr     = rc_mode ? ~w_pos[c_AW-1:0] : w_pos[c_AW-1:0];
    assign w_raw      = buf_img[w_addr*DATA_BITS +: DATA_BITS];

    if (DATA_BITS == $bits(base_t)) begin : g_pkg_cmp
      assign w_cmp = complement_base(w_raw);
    end else begin : g_inv_cmp
      assign w_cmp = ~w_raw;
    end

    assign frag[j*DATA_BITS +: DATA_BITS] =
      !w_in_range ? '0 : (rc_mode ? w_cmp : w_raw);
  end

endmodule
`default_nettype wire

// File: rtl/proj_fm_ring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : proj_fm_ring                                                     |
// | Purpose : N-deep ring of base buffers between the base stream producer and |
// |           the fragment consumer. Bases stream in with valid/ready; reads   |
// |           return a padded fragment of the oldest completed buffer with one |
// |           cycle of registered latency; the reader releases buffers.        |
// | Ports   : clk, rst_n (async, active-low)                                   |
// |           in_valid/in_wdata/in_ready - base write handshake                |
// |           rd_req/frag_idx/rc_mode    - fragment read request              |
// |           rd_release                 - free the current read buffer       |
// |           out_rdata/out_valid        - registered fragment, valid pulse   |
// |           rd_err                     - read/release with nothing complete |
// |           full_cnt                   - completed, unreleased buffers      |
// | Rev     : 1.0  initial ring-buffer release                                 |
// +----------------------------------------------------------------------------+
module proj_fm_ring
  import proj_fm_pkg::*;
#(
  parameter int BUFFER_COUNT = DEF_BUFFER_COUNT,
  parameter int BUF_DEPTH    = DEF_BUF_DEPTH,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int FRAG_BASES   = DEF_FRAG_BASES,
  parameter int IDX_LEN      = $clog2(BUF_DEPTH) + 1,
  parameter int FRAG_LEN     = FRAG_BASES * DATA_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [DATA_BITS-1:0]              in_wdata,
  output logic                              in_ready,
  input  logic                              rd_req,
  input  logic [IDX_LEN-1:0]                frag_idx,
  input  logic                              rc_mode,
  input  logic                              rd_release,
  output logic [FRAG_LEN-1:0]               out_rdata,
  output logic                              out_valid,
  output logic                              rd_err,
  output logic [$clog2(BUFFER_COUNT+1)-1:0] full_cnt
);

  localparam int c_AW = $clog2(BUF_DEPTH);
  localparam int c_BW = $clog2(BUFFER_COUNT);
  localparam int c_CW = $clog2(BUFFER_COUNT + 1);

  logic [DATA_BITS-1:0] r_mem [BUFFER_COUNT][BUF_DEPTH];

  logic [c_BW-1:0]     r_wr_buf;
  logic [c_BW-1:0]     r_rd_buf;
  logic [c_AW-1:0]     r_waddr;
  logic [c_CW-1:0]     r_full_cnt;
  logic [FRAG_LEN-1:0] r_out_rdata;
  logic                r_out_valid;
  logic                r_rd_err;

  logic                           w_have_buf;
  logic                           w_wr;
  logic                           w_complete;
  logic                           w_rel;
  logic                           w_rd;
  logic [BUF_DEPTH*DATA_BITS-1:0] w_rd_img;
  logic [FRAG_LEN-1:0]            w_frag;

  assign in_ready   = (r_full_cnt < c_CW'(BUFFER_COUNT));
  assign w_have_buf = (r_full_cnt != '0);
  assign w_wr       = in_valid & in_ready;
  assign w_complete = w_wr & (r_waddr == c_AW'(BUF_DEPTH - 1));
  assign w_rel      = rd_release & w_have_buf;
  assign w_rd       = rd_req & w_have_buf;

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_buf][r_waddr] <= in_wdata;
    end
  end

  // Image of the current read buffer. Uses the pre-release pointer, so a
  // read issued together with a release still sees the old buffer.
  always_comb begin
    w_rd_img = '0;
    for (int a = 0; a < BUF_DEPTH; a++) begin
      w_rd_img[a*DATA_BITS +: DATA_BITS] = r_mem[r_rd_buf][a];
    end
  end

  proj_fm_frag_extract #(
    .BUF_DEPTH  (BUF_DEPTH),
    .DATA_BITS  (DATA_BITS),
    .FRAG_BASES (FRAG_BASES),
    .IDX_LEN    (IDX_LEN),
    .FRAG_LEN   (FRAG_LEN)
  ) u_extract (
    .buf_img  (w_rd_img),
    .frag_idx (frag_idx),
    .rc_mode  (rc_mode),
    .frag     (w_frag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_buf    <= '0;
      r_rd_buf    <= '0;
      r_waddr     <= '0;
      r_full_cnt  <= '0;
      r_out_rdata <= '0;
      r_out_valid <= 1'b0;
      r_rd_err    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_waddr <= r_waddr + c_AW'(1);
      end
      if (w_complete) begin
        r_wr_buf <= (r_wr_buf == c_BW'(BUFFER_COUNT - 1)) ? '0 : r_wr_buf + c_BW'(1);
      end
      if (w_rel) begin
        r_rd_buf <= (r_rd_buf == c_BW'(BUFFER_COUNT - 1)) ? '0 : r_rd_buf + c_BW'(1);
      end
      // Simultaneous completion and release leave the count unchanged.
      if (w_complete && !w_rel) begin
        r_full_cnt <= r_full_cnt + c_CW'(1);
      end else if (!w_complete && w_rel) begin
        r_full_cnt <= r_full_cnt - c_CW'(1);
      end
      r_out_valid <= w_rd;
      if (w_rd) begin
        r_out_rdata <= w_frag;
      end
      r_rd_err <= (rd_req | rd_release) & ~w_have_buf;
    end
  end

  assign out_rdata = r_out_rdata;
  assign out_valid = r_out_valid;
  assign rd_err    = r_rd_err;
  assign full_cnt  = r_full_cnt;

endmodule
`default_nettype wire

// File: tb/tb_proj_fm_ring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_proj_fm_ring                                                  |
// | Purpose : Self-checking bench for proj_fm_ring (2 buffers x 32 bases).     |
// |           A reference model tracks ring contents and pointers; expected   |
// |           fragments are queued when a read is accepted and popped when    |
// |           the DUT presents out_valid.                                      |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial ring-buffer release                                 |
// +----------------------------------------------------------------------------+
module tb_proj_fm_ring;

  localparam int NB = 2;
  localparam int D  = 32;
  localparam int DB = 2;
  localparam int FB = 8;
  localparam int IL = 6;
  localparam int FL = FB * DB;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DB-1:0] in_wdata = '0;
  logic          in_ready;
  logic          rd_req = 1'b0;
  logic [IL-1:0] frag_idx = '0;
  logic          rc_mode = 1'b0;
  logic          rd_release = 1'b0;
  logic [FL-1:0] out_rdata;
  logic          out_valid;
  logic          rd_err;
  logic [CW-1:0] full_cnt;

  always #5 clk = ~clk;

  proj_fm_ring #(
    .BUFFER_COUNT (NB),
    .BUF_DEPTH    (D),
    .DATA_BITS    (DB),
    .FRAG_BASES   (FB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_wdata   (in_wdata),
    .in_ready   (in_ready),
    .rd_req     (rd_req),
    .frag_idx   (frag_idx),
    .rc_mode    (rc_mode),
    .rd_release (rd_release),
    .out_rdata  (out_rdata),
    .out_valid  (out_valid),
    .rd_err     (rd_err),
    .full_cnt   (full_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [DB-1:0] m_mem [NB][D];
  int            m_wb, m_wa, m_rb, m_cnt;
  bit            m_valid, m_err;
  logic [FL-1:0] q_exp [$];
  logic [FL-1:0] exp_f;

  function automatic logic [FL-1:0] model_frag(input int rb, input logic signed [IL-1:0] idx,
                                               input bit rc);
    logic [FL-1:0] f;
    int p;
    f = '0;
    for (int j = 0; j < FB; j++) begin
      p = int'(idx) + j;
      if (p >= 0 && p < D) f[j*DB +: DB] = rc ? ~m_mem[rb][D-1-p] : m_mem[rb][p];
    end
    return f;
  endfunction

  // One clock of stimulus; the model advances alongside the DUT.
  task automatic step(input bit v, input int wd, input bit req, input int idx,
                      input bit rc, input bit rel);
    bit wr, comp, relok, rdok;
    @(negedge clk);
    in_valid = v; in_wdata = DB'(wd); rd_req = req; frag_idx = IL'(idx);
    rc_mode = rc; rd_release = rel;
    wr    = v && (m_cnt < NB);
    comp  = wr && (m_wa == D - 1);
    relok = rel && (m_cnt > 0);
    rdok  = req && (m_cnt > 0);
    if (rdok) q_exp.push_back(model_frag(m_rb, frag_idx, rc));
    m_valid = rdok;
    m_err   = (req || rel) && (m_cnt == 0);
    @(posedge clk);
    if (wr) begin
      m_mem[m_wb][m_wa] = DB'(wd);
      m_wa = (m_wa + 1) % D;
      if (comp) m_wb = (m_wb + 1) % NB;
    end
    m_cnt = m_cnt + int'(comp) - int'(relok);
    if (relok) m_rb = (m_rb + 1) % NB;
    #1;
    in_valid = 1'b0; rd_req = 1'b0; rd_release = 1'b0;
  endtask

  task automatic write_bases(input int n, input int k0);
    for (int i = 0; i < n; i++) step(1'b1, (k0 + i) % 4, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic model_clear();
    m_wb = 0; m_wa = 0; m_rb = 0; m_cnt = 0; m_valid = 0; m_err = 0;
    q_exp.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); #2; rst_n = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_clear();
    @(negedge clk); @(negedge clk);
    n_cmp++; if (out_rdata !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", out_rdata); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (rd_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", rd_err); end
    n_cmp++; if (full_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", full_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  // Reads from the first buffer: plain, padded both sides, out of range, RC.
  task automatic test_reads();
    int            idx_t [6] = '{0, -3, 28, -8, 32, 1};
    bit            rc_t  [6] = '{0, 0, 0, 0, 0, 1};
    logic [FL-1:0] lit_t [6] = '{16'hE4E4, 16'h3900, 16'h00E4, 16'h0000, 16'h0000, 16'h3939};
    write_bases(D, 0);
    n_cmp++; if (full_cnt !== CW'(m_cnt) || m_cnt != 1) begin n_bad++; $display("FAIL rd_cnt: got %0d want 1", full_cnt); end
    for (int t = 0; t < 6; t++) begin
      // idx 32 does not fit in 6 bits and wraps to -32, still fully padded
      step(1'b0, 0, 1'b1, idx_t[t], rc_t[t], 1'b0);
      n_cmp++; if (out_valid !== m_valid) begin n_bad++; $display("FAIL rd_valid[%0d]: got %b want %b", t, out_valid, m_valid); end
      exp_f = (q_exp.size() > 0) ? q_exp.pop_front() : 'x;
      n_cmp++; if (out_rdata !== exp_f) begin n_bad++; $display("FAIL rd_model[%0d]: got %h want %h", t, out_rdata, exp_f); end
      n_cmp++; if (out_rdata !== lit_t[t]) begin n_bad++; $display("FAIL rd_const[%0d]: got %h want %h", t, out_rdata, lit_t[t]); end
    end
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rd_pulse: got %b want 0", out_valid); end
    n_cmp++; if (out_rdata !== 16'h3939) begin n_bad++; $display("FAIL rd_hold: got %h want 3939", out_rdata); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    write_bases(2 * D, 0);
    n_cmp++; if (full_cnt !== 2'd2) begin n_bad++; $display("FAIL bp_cnt_full: got %0d want 2", full_cnt); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
    // 65th base (value 3) offered while full, then with release in same cycle
    step(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    n_cmp++; if (full_cnt !== 2'd2 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall: got cnt %0d rdy %b want 2 0", full_cnt, in_ready); end
    step(1'b1, 3, 1'b0, 0, 1'b0, 1'b1);
    n_cmp++; if (full_cnt !== 2'd1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got cnt %0d rdy %b want 1 1", full_cnt, in_ready); end
    step(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    write_bases(D - 1, 65);
    n_cmp++; if (full_cnt !== CW'(m_cnt) || m_cnt != 2) begin n_bad++; $display("FAIL bp_refill: got %0d want 2", full_cnt); end
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    exp_f = (q_exp.size() > 0) ? q_exp.pop_front() : 'x;
    n_cmp++; if (out_rdata !== exp_f || out_rdata !== 16'hE4E7) begin n_bad++; $display("FAIL bp_landed: got %h want %h", out_rdata, exp_f); end
  endtask

  task automatic test_errors();
    do_reset();
    step(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL err_valid: got %b want 0", out_valid); end
    n_cmp++; if (rd_err !== m_err || !m_err) begin n_bad++; $display("FAIL err_read: got %b want 1", rd_err); end
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    n_cmp++; if (rd_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse: got %b want 0", rd_err); end
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    n_cmp++; if (rd_err !== 1'b1) begin n_bad++; $display("FAIL err_release: got %b want 1", rd_err); end
    n_cmp++; if (full_cnt !== '0) begin n_bad++; $display("FAIL err_cnt: got %0d want 0", full_cnt); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    write_bases(D, 0);
    write_bases(D - 1, D);
    step(1'b1, (2 * D - 1) % 4, 1'b0, 0, 1'b0, 1'b1);
    n_cmp++; if (full_cnt !== 2'd1 || m_cnt != 1) begin n_bad++; $display("FAIL sc_cnt: got %0d want 1", full_cnt); end
    n_cmp++; if (dut.r_rd_buf !== 1'(m_rb) || m_rb != 1) begin n_bad++; $display("FAIL sc_rdbuf: got %0d want 1", dut.r_rd_buf); end
    // Leave state non-trivial, then reset asynchronously mid-buffer.
    write_bases(5, 0);
    step(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    exp_f = (q_exp.size() > 0) ? q_exp.pop_front() : 'x;
    n_cmp++; if (out_rdata !== exp_f) begin n_bad++; $display("FAIL sc_pre_rst: got %h want %h", out_rdata, exp_f); end
    @(negedge clk); #2; rst_n = 1'b0; #1;
    model_clear();
    n_cmp++; if (out_rdata !== '0 || out_valid !== 1'b0 || rd_err !== 1'b0 || full_cnt !== '0)
      begin n_bad++; $display("FAIL sc_rst_out: got %h %b %b %0d want 0 0 0 0", out_rdata, out_valid, rd_err, full_cnt); end
    @(negedge clk); rst_n = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL sc_rst_ready: got %b want 1", in_ready); end
    write_bases(D - 1, 0);
    n_cmp++; if (full_cnt !== '0) begin n_bad++; $display("FAIL sc_waddr31: got %0d want 0", full_cnt); end
    write_bases(1, D - 1);
    n_cmp++; if (full_cnt !== 2'd1) begin n_bad++; $display("FAIL sc_waddr32: got %0d want 1", full_cnt); end
  endtask

  initial begin
    test_reset();
    test_reads();
    test_back_to_back();
    test_errors();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
